layer_scan: RTL and testbench

LAYER_SCAN -- requirements
Module: layer_scan

---
 rtl/layer_scan_pkg.sv | 29 ++
 rtl/layer_scan_if.sv | 26 ++
 rtl/layer_scan_lane_out.sv | 29 ++
 rtl/layer_scan.sv | 170 +++++++++++++++++
 tb/tb_layer_scan.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/layer_scan_pkg.sv
// Shared types and defaults for the eight-layer NeoPixel scanner.
package layer_pkg;

    localparam int LAYERS = 8;
    localparam int PIXELS = 64;
    localparam int ADDR_W = 6;
    localparam int WORD_W = 24;

    localparam logic [7:0]  T0H        = 8'd20;
    localparam logic [7:0]  T1H        = 8'd40;
    localparam logic [7:0]  TBIT       = 8'd100;
    localparam logic [15:0] RST_CYCLES = 16'd4000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } state_t;

    typedef logic [LAYERS-1:0][WORD_W-1:0] layer_words_t;

    // A one-cycle bit period cannot hold a high and a low phase.
    function automatic logic [7:0] clamp_tbit(input logic [7:0] t);
        return (t < 8'd2) ? 8'd2 : t;
    endfunction

endpackage

// File: rtl/layer_scan_if.sv
// Frame control, timing, layer RAM read port and serial outputs of the scanner.
interface layer_scan_if;
    import layer_pkg::*;

    logic               frame_rdy_in;
    logic [7:0]         t0h_in;
    logic [7:0]         t1h_in;
    logic [7:0]         tbit_in;
    logic               rd_en_out;
    logic [ADDR_W-1:0]  rd_addr_out;
    layer_words_t       rd_data_in;
    logic [LAYERS-1:0]  data_out;
    logic               busy_out;
    logic               done_out;

    modport master (
        output frame_rdy_in, t0h_in, t1h_in, tbit_in, rd_data_in,
        input  rd_en_out, rd_addr_out, data_out, busy_out, done_out
    );

    modport slave (
        input  frame_rdy_in, t0h_in, t1h_in, tbit_in, rd_data_in,
        output rd_en_out, rd_addr_out, data_out, busy_out, done_out
    );

endinterface

// File: rtl/layer_scan_lane_out.sv
// One serial lane: GRB shift register, MSB first, and the high-time comparator.
module lane_out (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic        active,
    input  logic [23:0] word,
    input  logic [7:0]  cnt,
    input  logic [7:0]  t0h,
    input  logic [7:0]  t1h,
    output logic        line
);
    logic [23:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= word;
        end else if (shift) begin
            shreg <= {shreg[22:0], 1'b0};
        end
    end

    // High time >= period gives a solid high, zero gives a solid low.
    assign line = active && (cnt < (shreg[23] ? t1h : t0h));

endmodule

// File: rtl/layer_scan.sv
// Scans PIXELS words from eight layer RAMs out onto eight NeoPixel lines in lockstep.
//   state | meaning
//   IDLE  | waiting for frame_rdy_in (or a pending frame)
//   FETCH | read address 0
//   LOAD  | capture pixel 0 into the lane shift registers
//   SEND  | serialise 24 bits per pixel, prefetching the next pixel during bit 0
//   LATCH | hold all lines low for RST_CYCLES, done_out on the last cycle
module layer_scan #(
    parameter logic [15:0] RST_CYCLES = layer_pkg::RST_CYCLES,
    parameter int          PIXELS     = layer_pkg::PIXELS
) (
    input logic         clk_in,
    input logic         rst_n_in,
    layer_scan_if.slave bus
);
    import layer_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIXELS - 1);
    localparam logic [15:0]       LATCH_LOAD = (RST_CYCLES == 16'd0) ? 16'd0 : RST_CYCLES - 16'd1;

    state_t             state, state_nxt;
    logic [7:0]         t0h, t1h, tbit;
    logic [7:0]         cnt;
    logic [4:0]         bit_idx;
    logic [ADDR_W-1:0]  addr;
    logic [15:0]        latch_cnt;
    logic               pending;
    logic               pf_cap;
    layer_words_t       staging;
    layer_words_t       load_word;

    logic               go, start, bit_end, pix_end, last_pixel, prefetch, lat_done;
    logic               lane_load, lane_shift, lane_active;
    logic               rd_en, busy, done;
    logic [ADDR_W-1:0]  rd_addr;
    logic [LAYERS-1:0]  lines;

    assign go          = bus.frame_rdy_in || pending;
    assign lat_done    = (state == LATCH) && (latch_cnt == 16'd0);
    assign start       = ((state == IDLE) || lat_done) && go;
    assign bit_end     = (state == SEND) && (cnt == tbit - 8'd1);
    assign pix_end     = bit_end && (bit_idx == 5'd0);
    assign last_pixel  = (addr == LAST_ADDR);
    assign prefetch    = (state == SEND) && (bit_idx == 5'd0) && (cnt == 8'd0) && !last_pixel;

    assign lane_active = (state == SEND);
    assign lane_load   = (state == LOAD) || (pix_end && !last_pixel);
    assign lane_shift  = bit_end && (bit_idx != 5'd0);
    // With tbit=2 the prefetched word arrives on the very cycle it is needed.
    assign load_word   = ((state == LOAD) || pf_cap) ? bus.rd_data_in : staging;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go) state_nxt = FETCH;
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (prefetch) begin
                    rd_en   = 1'b1;
                    rd_addr = addr + ADDR_W'(1);
                end
                if (pix_end && last_pixel) state_nxt = LATCH;
            end
            LATCH: begin
                if (lat_done) begin
                    done      = 1'b1;
                    state_nxt = go ? FETCH : IDLE;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            t0h       <= '0;
            t1h       <= '0;
            tbit      <= 8'd2;
            cnt       <= '0;
            bit_idx   <= '0;
            addr      <= '0;
            latch_cnt <= '0;
            pending   <= 1'b0;
            pf_cap    <= 1'b0;
            staging   <= '0;
        end else begin
            pf_cap <= prefetch;
            if (pf_cap) staging <= bus.rd_data_in;

            // Timing is frozen for the whole frame; extra requests collapse into one.
            if (start) begin
                t0h     <= bus.t0h_in;
                t1h     <= bus.t1h_in;
                tbit    <= clamp_tbit(bus.tbit_in);
                pending <= 1'b0;
            end else if (bus.frame_rdy_in && (state != IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                FETCH: addr <= '0;
                LOAD: begin
                    cnt     <= '0;
                    bit_idx <= 5'd23;
                end
                SEND: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 5'd1;
                        end else if (!last_pixel) begin
                            bit_idx <= 5'd23;
                            addr    <= addr + ADDR_W'(1);
                        end else begin
                            latch_cnt <= LATCH_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LATCH: if (!lat_done) latch_cnt <= latch_cnt - 16'd1;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < LAYERS; i++) begin : g_lane
        lane_out u_lane (
            .clk    (clk_in),
            .rst_n  (rst_n_in),
            .load   (lane_load),
            .shift  (lane_shift),
            .active (lane_active),
            .word   (load_word[i]),
            .cnt    (cnt),
            .t0h    (t0h),
            .t1h    (t1h),
            .line   (lines[i])
        );
    end

    assign bus.data_out    = lines;
    assign bus.rd_en_out   = rd_en;
    assign bus.rd_addr_out = rd_addr;
    assign bus.busy_out    = busy;
    assign bus.done_out    = done;

endmodule

// File: tb/tb_layer_scan.sv
// Cycle-exact check of layer_scan against a waveform model computed from pixel/bit/phase arithmetic.
module tb_layer_scan;
    import layer_pkg::*;

    localparam int R = 60;
    localparam int P = 64;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;

    layer_scan_if bus ();

    layer_scan #(.RST_CYCLES(16'(R)), .PIXELS(P)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [23:0]  mem [P][LAYERS];
    layer_words_t rd_q = '0;

    always @(posedge clk_in) begin
        if (bus.rd_en_out === 1'b1) begin
            for (int i = 0; i < LAYERS; i++) rd_q[i] <= mem[bus.rd_addr_out][i];
        end
    end
    assign bus.rd_data_in = rd_q;

    int total = 0;
    int bad   = 0;
    bit aborted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Line levels at SEND cycle k: which pixel, which bit (MSB first), where in the bit period.
    function automatic logic [7:0] model_lines(input int k, input int tb, input int t0, input int t1);
        logic [7:0] v;
        int p, r, b, ph;
        p  = k / (24 * tb);
        r  = k % (24 * tb);
        b  = 23 - r / tb;
        ph = r % tb;
        for (int i = 0; i < LAYERS; i++) v[i] = (ph < (mem[p][i][b] ? t1 : t0));
        return v;
    endfunction

    task automatic fill_random();
        for (int a = 0; a < P; a++)
            for (int i = 0; i < LAYERS; i++) mem[a][i] = 24'($urandom);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_in);
            if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0 ||
                bus.rd_en_out !== 1'b0 || bus.data_out !== 8'h00) hits++;
        end
        chk(name, hits, 0);
    endtask

    // Entered at the negedge of cycle 0 (the cycle frame_rdy_in is sampled, or the previous done cycle).
    task automatic run_frame(input string name, input int n_pend, input int chg_c,
                             input logic [7:0] nt0, input logic [7:0] nt1, input logic [7:0] ntb,
                             input int abort_c, output bit ab);
        int t0, t1, tb, n, last_c, k, derr, rerr, cerr, first_bad, done_c, e_addr;
        logic [7:0] e_data;
        logic       e_en, e_done;
        t0 = int'(bus.t0h_in);
        t1 = int'(bus.t1h_in);
        tb = (bus.tbit_in < 8'd2) ? 2 : int'(bus.tbit_in);
        n = P * 24 * tb;
        last_c = n + R + 2;
        derr = 0; rerr = 0; cerr = 0; first_bad = -1; done_c = -1; ab = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk_in);
            bus.frame_rdy_in = (c % 300 == 0) && (c / 300 <= n_pend);
            if (c == chg_c) begin
                bus.t0h_in  = nt0;
                bus.t1h_in  = nt1;
                bus.tbit_in = ntb;
            end
            e_data = '0; e_en = 1'b0; e_addr = 0;
            e_done = (c == last_c);
            if (c == 1) begin
                e_en = 1'b1;
            end else if (c >= 3 && c <= n + 2) begin
                k = c - 3;
                e_data = model_lines(k, tb, t0, t1);
                if (k % (24 * tb) == 23 * tb && k / (24 * tb) < P - 1) begin
                    e_en   = 1'b1;
                    e_addr = k / (24 * tb) + 1;
                end
            end
            if (bus.data_out !== e_data) begin
                derr++;
                if (first_bad < 0) first_bad = c;
            end
            if (bus.rd_en_out !== e_en || (e_en && bus.rd_addr_out !== 6'(e_addr))) rerr++;
            if (bus.busy_out !== 1'b1 || bus.done_out !== e_done) cerr++;
            if (bus.done_out === 1'b1 && done_c < 0) done_c = c;
            if (c == abort_c) begin
                rst_n_in = 1'b0;
                #1;
                chk($sformatf("%s reset lines", name), bus.data_out, 0);
                chk($sformatf("%s reset rd_en", name), bus.rd_en_out, 0);
                chk($sformatf("%s reset rd_addr", name), bus.rd_addr_out, 0);
                chk($sformatf("%s reset busy", name), bus.busy_out, 0);
                chk($sformatf("%s reset done", name), bus.done_out, 0);
                ab = 1'b1;
                break;
            end
        end
        chk($sformatf("%s line errors (first bad cycle %0d)", name, first_bad), derr, 0);
        chk($sformatf("%s read errors", name), rerr, 0);
        chk($sformatf("%s busy/done errors", name), cerr, 0);
        if (!ab) chk($sformatf("%s done cycle", name), done_c, last_c);
    endtask

    initial begin
        bus.frame_rdy_in = 1'b0;
        bus.t0h_in       = T0H;
        bus.t1h_in       = T1H;
        bus.tbit_in      = TBIT;
        fill_random();
        #2 rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("reset data_out", bus.data_out, 0);
        chk("reset rd_en", bus.rd_en_out, 0);
        chk("reset rd_addr", bus.rd_addr_out, 0);
        chk("reset busy", bus.busy_out, 0);
        chk("reset done", bus.done_out, 0);
        rst_n_in = 1'b1;
        idle_check("idle after reset", 5);

        // Three requests mid-frame plus a timing change: one extra frame with the new timing.
        fill_random();
        bus.t0h_in = 8'd1; bus.t1h_in = 8'd3; bus.tbit_in = 8'd4;
        bus.frame_rdy_in = 1'b1;
        run_frame("frameA", 3, 50, 8'd2, 8'd5, 8'd7, 0, aborted);
        run_frame("frameB", 0, 0, 8'd0, 8'd0, 8'd0, 0, aborted);
        idle_check("no third frame", 40);

        // Solid high / solid low bits.
        fill_random();
        bus.t0h_in = 8'd0; bus.t1h_in = 8'd255; bus.tbit_in = 8'd10;
        bus.frame_rdy_in = 1'b1;
        run_frame("frameC", 0, 0, 8'd0, 8'd0, 8'd0, 0, aborted);
        idle_check("idle after C", 3);

        // A period of 1 behaves as 2.
        bus.t0h_in = 8'd1; bus.t1h_in = 8'd2; bus.tbit_in = 8'd1;
        bus.frame_rdy_in = 1'b1;
        run_frame("frameD", 0, 0, 8'd0, 8'd0, 8'd0, 0, aborted);
        idle_check("idle after D", 3);

        // Nominal timing, first two pixels, reset at the start of pixel 2.
        fill_random();
        mem[0][0] = 24'hFF0000;
        bus.t0h_in = 8'd20; bus.t1h_in = 8'd40; bus.tbit_in = 8'd100;
        bus.frame_rdy_in = 1'b1;
        run_frame("frameE", 0, 0, 8'd0, 8'd0, 8'd0, 3 + 2 * 2400, aborted);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        idle_check("idle after reset E", 10);

        // Distinct one-hot pattern per layer, reset at pixel 30.
        for (int a = 0; a < P; a++)
            for (int i = 0; i < LAYERS; i++) mem[a][i] = 24'h000001 << i;
        bus.t0h_in = 8'd1; bus.t1h_in = 8'd3; bus.tbit_in = 8'd4;
        bus.frame_rdy_in = 1'b1;
        run_frame("frameF", 0, 0, 8'd0, 8'd0, 8'd0, 3 + 30 * 96, aborted);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        idle_check("idle after reset F", 10);

        // Clean full frame after the abort.
        fill_random();
        bus.t0h_in = 8'd1; bus.t1h_in = 8'd2; bus.tbit_in = 8'd3;
        bus.frame_rdy_in = 1'b1;
        run_frame("frameG", 0, 0, 8'd0, 8'd0, 8'd0, 0, aborted);
        idle_check("idle after G", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
